// File: rtl/poly_addsub_lanes_if.sv
// Handshake and coefficient bus for poly_addsub_lanes.
// The master side drives the input beat and out_ready; the slave side is the adder.
interface poly_addsub_lanes_if #(
  parameter int W     = 24,
  parameter int LANES = 2
) ();
  logic               in_flag;
  logic               in_ready;
  logic               in_op;
  logic [LANES*W-1:0] din1;
  logic [LANES*W-1:0] din2;
  logic [LANES*W-1:0] dout;
  logic               out_flag;
  logic               out_ready;
  logic               out_last;
  logic               out_done;
  logic               err;

  modport master (
    output in_flag, in_op, din1, din2, out_ready,
    input  in_ready, dout, out_flag, out_last, out_done, err
  );

  modport slave (
    input  in_flag, in_op, din1, din2, out_ready,
    output in_ready, dout, out_flag, out_last, out_done, err
  );
endinterface

// File: rtl/poly_addsub_lanes.sv
// Lane-parallel modular add/sub (mod Q) of coefficient streams, two-stage
// ready/valid pipeline with polynomial framing (out_last/out_done) and sticky err.
module poly_addsub_lanes #(
  parameter int          W     = 24,
  parameter int          LANES = 2,
  parameter int unsigned Q     = 16515073,
  parameter int          BEATS = 128
) (
  input  logic          clk,
  input  logic          rst,
  poly_addsub_lanes_if.slave bus
);

  localparam int             CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0]  LAST_BEAT = CW'(BEATS - 1);
  localparam logic [W:0]     Q_T       = (W+1)'(Q);
  localparam logic [W-1:0]   Q_W       = W'(Q);

  logic                   s1_valid_q, s1_valid_d;
  logic [LANES*(W+1)-1:0] s1_t_q, s1_t_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [LANES*W-1:0]     dout_q, dout_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   adv1, adv2, in_xfer, out_xfer, bad;
  logic [W:0]             a_ext, b_ext, t_cur, r_cur;

  always_comb begin
    adv2       = ~s2_valid_q | bus.out_ready;
    adv1       = ~s1_valid_q | adv2;
    in_xfer    = bus.in_flag & adv1;
    out_xfer   = s2_valid_q & bus.out_ready;

    s1_valid_d = s1_valid_q;
    s1_t_d     = s1_t_q;
    s2_valid_d = s2_valid_q;
    dout_d     = dout_q;
    cnt_d      = cnt_q;
    bad        = 1'b0;
    a_ext      = '0;
    b_ext      = '0;
    t_cur      = '0;
    r_cur      = '0;

    // Stage 1: add is pre-biased by -Q so both ops need only a conditional +Q later.
    if (adv1) begin
      s1_valid_d = in_xfer;
      for (int k = 0; k < LANES; k++) begin
        a_ext = {1'b0, bus.din1[k*W +: W]};
        b_ext = {1'b0, bus.din2[k*W +: W]};
        if (bus.din1[k*W +: W] >= Q_W || bus.din2[k*W +: W] >= Q_W) bad = 1'b1;
        s1_t_d[k*(W+1) +: (W+1)] = bus.in_op ? (a_ext - b_ext) : (a_ext + b_ext - Q_T);
      end
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (bus.din1[k*W +: W] >= Q_W || bus.din2[k*W +: W] >= Q_W) bad = 1'b1;
      end
    end

    if (adv2) begin
      s2_valid_d = s1_valid_q;
      for (int k = 0; k < LANES; k++) begin
        t_cur = s1_t_q[k*(W+1) +: (W+1)];
        r_cur = t_cur + (t_cur[W] ? Q_T : '0);
        dout_d[k*W +: W] = s1_valid_q ? r_cur[W-1:0] : '0;
      end
    end

    if (out_xfer) cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CW'(1);

    done_d = out_xfer & (cnt_q == LAST_BEAT);
    err_d  = err_q | (in_xfer & bad);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_t_q     <= '0;
      s2_valid_q <= 1'b0;
      dout_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_t_q     <= s1_t_d;
      s2_valid_q <= s2_valid_d;
      dout_q     <= dout_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready = adv1;
  assign bus.dout     = dout_q;
  assign bus.out_flag = s2_valid_q;
  assign bus.out_last = s2_valid_q & (cnt_q == LAST_BEAT);
  assign bus.out_done = done_q;
  assign bus.err      = err_q;

endmodule
